// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// steers the shared ALU, memory port and register file. The Moore outputs are
// registered: each one is computed from the next state and loaded together
// with the state register. The only exception is the FETCH-phase IR/PC write
// strobes, which are gated by mem_ready in the same cycle.
module multicycle_control #(
    parameter logic [2:0] ALUOP_ADD   = 3'b010,
    parameter logic [2:0] ALUOP_SUB   = 3'b110,
    parameter logic [2:0] ALUOP_RTYPE = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Control word of one state. The fetch bit marks the phase whose IR/PC
    // write strobes are qualified by mem_ready.
    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic   illegal_reg;
    logic   opcode_known;

    // Moore output table: every field is zero unless the state asserts it.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Flag whether the IR opcode is one this controller can execute.
    always_comb begin
        opcode_known = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_known = 1'b1;
            default: opcode_known = 1'b0;
        endcase
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_next = S_R_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_ADDI:       state_next = S_ADDI_EXEC;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_FETCH;
                endcase
            end
            // Only LW and SW reach this state, so SW vs. anything else suffices.
            S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    // State, registered control word and sticky illegal flag; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            ctrl_reg    <= decode_ctrl(S_FETCH);
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode_ctrl(state_next);
            if (state_reg == S_DECODE && !opcode_known) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    assign pc_write      = ctrl_reg.pc_write | (ctrl_reg.fetch & mem_ready);
    assign ir_write      = ctrl_reg.fetch & mem_ready;
    assign pc_write_cond = ctrl_reg.pc_write_cond;
    assign i_or_d        = ctrl_reg.i_or_d;
    assign mem_read      = ctrl_reg.mem_read;
    assign mem_write     = ctrl_reg.mem_write;
    assign mem_to_reg    = ctrl_reg.mem_to_reg;
    assign reg_dst       = ctrl_reg.reg_dst;
    assign reg_write     = ctrl_reg.reg_write;
    assign alu_src_a     = ctrl_reg.alu_src_a;
    assign alu_src_b     = ctrl_reg.alu_src_b;
    assign pc_source     = ctrl_reg.pc_source;
    assign alu_op        = ctrl_reg.alu_op;
    assign illegal       = illegal_reg;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle CPU datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU between PC increment, address calculation and R-type execution.
- Drives the 3-bit ALUop consumed by alu_control: ALUop 3'b111 means "decode function_code"; any other value is passed straight through as the ALU operation.
- Waits on a ready handshake from the unified instruction/data memory.

Parameters:
- ALUOP_ADD, 3'b010, ALUop for PC+4, address calculation and addi.
- ALUOP_SUB, 3'b110, ALUop for beq compare.
- ALUOP_RTYPE, 3'b111, ALUop telling alu_control to decode function_code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26].
- mem_ready  in  1  memory completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU operand B: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  out  3  to alu_control ALUop.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Output style: Moore outputs; all control outputs are 0 unless listed for the current state.
- Exception: pc_write and ir_write in FETCH are qualified by mem_ready.
- Opcodes decoded in DECODE:
  - R = 000000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ALUOP_ADD, pc_source = 00.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in that same cycle, next state DECODE.
  - When mem_ready = 0: stay in FETCH, no writes.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = ALUOP_ADD (branch target precompute).
  - Next state by opcode: R -> R_EXEC; LW/SW -> MEM_ADDR; BEQ -> BRANCH; ADDI -> ADDI_EXEC; J -> JUMP.
  - Any other opcode -> FETCH, with illegal set to 1.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = ALUOP_ADD.
  - Next state: LW -> MEM_READ; SW -> MEM_WRITE.
  - Branches on the opcode held stable in the IR.
- MEM_READ:
  - Outputs: mem_read = 1, i_or_d = 1.
  - Stay until mem_ready = 1, then go to MEM_WB.
- MEM_WB:
  - Outputs: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - Next state FETCH.
- MEM_WRITE:
  - Outputs: mem_write = 1, i_or_d = 1.
  - Stay until mem_ready = 1, then go to FETCH.
- R_EXEC:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = ALUOP_RTYPE.
  - Next state R_WB.
- R_WB:
  - Outputs: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
  - Next state FETCH.
- ADDI_EXEC:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = ALUOP_ADD.
  - Next state ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = ALUOP_SUB, pc_write_cond = 1, pc_source = 01.
  - Next state FETCH.
- JUMP:
  - Outputs: pc_write = 1, pc_source = 10.
  - Next state FETCH.
- Cycle counts with mem_ready tied 1:
  - R = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
  - SW = 4
  - LW = 5
  - Each wait cycle on mem_ready adds exactly 1 cycle to FETCH, MEM_READ or MEM_WRITE.
- Reset:
  - reset = 1 at a clock edge forces state FETCH and clears illegal.
  - Outputs take their FETCH values on the first cycle after reset.
  - Reset mid-instruction (including during a memory wait) aborts the instruction with no reg_write or pc_write in the following cycle other than FETCH's qualified pc_write.
  - Reset has priority over all transitions.
- illegal: once set, stays 1 until reset; execution continues with the next fetch.
- Undefined state encodings recover to FETCH on the next clock.

Test Plan:
- Reset then R-type: reset high 2 cycles, opcode = 000000, mem_ready = 1.
  - Required sequence: FETCH(ir_write = 1, pc_write = 1, alu_op = 010), DECODE(alu_src_b = 11), R_EXEC(alu_op = 111, alu_src_a = 1), R_WB(reg_write = 1, reg_dst = 1), then FETCH.
- LW with wait states: opcode = 100011, mem_ready low for 2 cycles in MEM_READ.
  - Required: MEM_READ lasts 3 cycles with mem_read = 1, i_or_d = 1; MEM_WB has reg_write = 1, mem_to_reg = 1; total 7 cycles.
- Fetch stall: mem_ready = 0 for 3 cycles in FETCH.
  - Required: ir_write = 0 and pc_write = 0 for those cycles; both are 1 in exactly the single cycle mem_ready = 1.
- BEQ then J:
  - BEQ: pc_write_cond = 1, pc_source = 01, alu_op = 110, 3 cycles total.
  - J: pc_write = 1, pc_source = 10, 3 cycles total.
- Illegal opcode 111111 at DECODE:
  - Required: illegal rises and stays 1 through the following ADDI instruction (4 cycles, ADDI_WB reg_write = 1, reg_dst = 0); reset clears it.
- Reset during MEM_WRITE wait (SW, mem_ready = 0):
  - Required: next cycle is FETCH, mem_write = 0, no reg_write.
